// File: rtl/brent_kung_pipe_adder_if.sv
// Operand/result stream bundle for brent_kung_pipe_adder.
// out_ovf is present only when BK_OVF_EN is defined.
interface brent_kung_pipe_adder_if #(
    parameter int WIDTH = 16
) ();
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_a;
    logic [WIDTH-1:0] in_b;
    logic             in_cin;
    logic             out_valid;
    logic             out_ready;
    logic [WIDTH-1:0] out_sum;
    logic             out_cout;
`ifdef BK_OVF_EN
    logic             out_ovf;
`endif

    // The adder is the slave; whoever feeds operands and takes results is the master.
    modport slave (
        input  in_valid, in_a, in_b, in_cin, out_ready,
        output in_ready, out_valid, out_sum, out_cout
`ifdef BK_OVF_EN
        , output out_ovf
`endif
    );

    modport master (
        output in_valid, in_a, in_b, in_cin, out_ready,
        input  in_ready, out_valid, out_sum, out_cout
`ifdef BK_OVF_EN
        , input out_ovf
`endif
    );
endinterface

// File: rtl/brent_kung_pipe_adder.sv
// Pipelined Brent-Kung prefix adder (s = a + b + cin) with elastic valid/ready ranks.
// Define BK_OVF_EN to add the signed-overflow output out_ovf.
module brent_kung_pipe_adder #(
    parameter int WIDTH  = 16,
    parameter int STAGES = 2
) (
    input  logic                   clk,
    input  logic                   rst_n,
    brent_kung_pipe_adder_if.slave bus
);
    localparam int LOG  = $clog2(WIDTH);
    localparam int LVLS = 2 * LOG - 1;

    typedef struct packed {
        logic [WIDTH-1:0] g;    // group generate, combined as the levels progress
        logic [WIDTH-1:0] pp;   // group propagate
        logic [WIDTH-1:0] p;    // bit propagate, kept for the final sum XOR
        logic             cin;  // c[0]
    } state_t;

    // One prefix level: levels 0..LOG-1 are the up-sweep, the rest the down-sweep.
    function automatic state_t apply_level(input state_t s, input int lvl);
        state_t r;
        int     d;
        int     src;
        r = s;
        if (lvl < LOG) begin
            d = 1 << lvl;
            for (int i = 0; i < WIDTH; i++) begin
                src = (i >= d) ? i - d : i;
                if (((i + 1) % (2 * d)) == 0) begin
                    r.g[i]  = s.g[i] | (s.pp[i] & s.g[src]);
                    r.pp[i] = s.pp[i] & s.pp[src];
                end
            end
        end else begin
            d = 1 << (2 * LOG - 2 - lvl);
            for (int i = 0; i < WIDTH; i++) begin
                src = (i >= d) ? i - d : i;
                if ((i >= 2 * d) && (((i + 1) % (2 * d)) == d)) begin
                    r.g[i]  = s.g[i] | (s.pp[i] & s.g[src]);
                    r.pp[i] = s.pp[i] & s.pp[src];
                end
            end
        end
        return r;
    endfunction

    function automatic state_t run_levels(input state_t s, input int lo, input int hi);
        state_t r;
        r = s;
        for (int j = 0; j < LVLS; j++) begin
            if ((j >= lo) && (j < hi)) begin
                r = apply_level(r, j);
            end
        end
        return r;
    endfunction

    state_t            in_state;
    state_t            rank_src [STAGES];
    state_t            rank_nxt [STAGES];
    state_t            rank_reg [STAGES];
    logic [STAGES-1:0] valid_reg;
    logic [STAGES-1:0] valid_up;
    logic [STAGES-1:0] adv;

    // Carry-in is folded into bit 0's generate so every G[i:0] already includes it.
    always_comb begin
        in_state.p    = bus.in_a ^ bus.in_b;
        in_state.pp   = bus.in_a ^ bus.in_b;
        in_state.g    = bus.in_a & bus.in_b;
        in_state.g[0] = (bus.in_a[0] & bus.in_b[0]) | ((bus.in_a[0] ^ bus.in_b[0]) & bus.in_cin);
        in_state.cin  = bus.in_cin;
    end

    // Each rank owns a contiguous slice of prefix levels, spread as evenly as possible.
    for (genvar gi = 0; gi < STAGES; gi++) begin : g_rank
        localparam int LO = (gi * LVLS) / STAGES;
        localparam int HI = ((gi + 1) * LVLS) / STAGES;
        if (gi == 0) begin : g_head
            assign rank_src[gi] = in_state;
        end else begin : g_body
            assign rank_src[gi] = rank_reg[gi-1];
        end
        assign rank_nxt[gi] = run_levels(rank_src[gi], LO, HI);
    end

    // A rank may load when downstream moves or when it holds a bubble.
    always_comb begin
        adv            = '0;
        valid_up       = '0;
        adv[STAGES-1]  = bus.out_ready | ~valid_reg[STAGES-1];
        for (int k = STAGES - 2; k >= 0; k--) begin
            adv[k] = adv[k+1] | ~valid_reg[k];
        end
        valid_up[0] = bus.in_valid;
        for (int k = 1; k < STAGES; k++) begin
            valid_up[k] = valid_reg[k-1];
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            valid_reg <= '0;
            for (int k = 0; k < STAGES; k++) begin
                rank_reg[k] <= '0;
            end
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (adv[k]) begin
                    valid_reg[k] <= valid_up[k];
                    rank_reg[k]  <= rank_nxt[k];
                end
            end
        end
    end

    // The last rank holds the finished prefix; c[i] = G[i-1:0], c[0] = cin.
    assign bus.in_ready  = adv[0];
    assign bus.out_valid = valid_reg[STAGES-1];
    assign bus.out_sum   = rank_reg[STAGES-1].p ^ {rank_reg[STAGES-1].g[WIDTH-2:0], rank_reg[STAGES-1].cin};
    assign bus.out_cout  = rank_reg[STAGES-1].g[WIDTH-1];
`ifdef BK_OVF_EN
    assign bus.out_ovf   = rank_reg[STAGES-1].g[WIDTH-2] ^ rank_reg[STAGES-1].g[WIDTH-1];
`endif

endmodule
